// File: rtl/bcd_seg_display.sv
// Converts an asynchronous 8-bit value to three BCD digits using a sequential
// shift-add-3 engine, and drives three seven-segment displays from the result.
module bcd_seg_display #(
   parameter bit BLANK_LEADING  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        iCLK_50,
   input  logic        iRST_N,
   input  logic [7:0]  iVALUE,
   output logic [6:0]  oHEX0,
   output logic [6:0]  oHEX1,
   output logic [6:0]  oHEX2,
   output logic [11:0] oBCD,
   output logic        oBUSY,
   output logic        oDONE
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } convState_t;

   localparam logic [6:0] SEG_ZERO   = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
   localparam logic [6:0] SEG_BLANK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0] SEG_LEADRST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

   // Active-low DE2 pattern, inverted for active-high panels; 10-15 show blank.
   function automatic logic [6:0] segEncode(input logic [3:0] digit, input logic blank);
      logic [6:0] code;
      if (blank) begin
         code = 7'h7F;
      end else begin
         case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
         endcase
      end
      return SEG_ACTIVE_LOW ? code : ~code;
   endfunction

   function automatic logic [3:0] addThree(input logic [3:0] nibble);
      return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
   endfunction

   convState_t  state_r;
   logic [7:0]  sync1_r;
   logic [7:0]  sync2_r;
   logic [7:0]  last_r;
   logic [7:0]  sh_r;
   logic [11:0] bcd_r;
   logic [2:0]  count_r;

   logic        startConv_s;
   logic [11:0] nextBcd_s;
   logic        hundBlank_s;
   logic        tensBlank_s;

   // Start condition, next accumulator value and leading-zero blanking.
   always_comb begin
      startConv_s = (sync1_r == sync2_r) && (sync2_r != last_r);
      // Hundreds stays <= 2 for an 8-bit input, so it never needs the +3 step.
      nextBcd_s   = {bcd_r[10:8], addThree(bcd_r[7:4]), addThree(bcd_r[3:0]), sh_r[7]};
      hundBlank_s = BLANK_LEADING && (bcd_r[11:8] == 4'd0);
      tensBlank_s = hundBlank_s && (bcd_r[7:4] == 4'd0);
   end

   // Input double-sampling, conversion FSM and registered display outputs.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_r <= IDLE;
         sync1_r <= 8'd0;
         sync2_r <= 8'd0;
         last_r  <= 8'd0;
         sh_r    <= 8'd0;
         bcd_r   <= 12'd0;
         count_r <= 3'd0;
         oBCD    <= 12'd0;
         oHEX0   <= SEG_ZERO;
         oHEX1   <= SEG_LEADRST;
         oHEX2   <= SEG_LEADRST;
         oBUSY   <= 1'b0;
         oDONE   <= 1'b0;
      end else begin
         sync1_r <= iVALUE;
         sync2_r <= sync1_r;
         oDONE   <= 1'b0;
         case (state_r)
            IDLE: begin
               // Busy shows a one-cycle gap after each result, even back-to-back.
               oBUSY <= startConv_s && !oDONE;
               if (startConv_s) begin
                  sh_r    <= sync2_r;
                  bcd_r   <= 12'd0;
                  last_r  <= sync2_r;
                  count_r <= 3'd0;
                  state_r <= SHIFT;
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               oBUSY   <= 1'b1;
               bcd_r   <= nextBcd_s;
               sh_r    <= {sh_r[6:0], 1'b0};
               count_r <= count_r + 3'd1;
               if (count_r == 3'd7) begin
                  state_r <= LATCH;
               end else begin
                  state_r <= SHIFT;
               end
            end
            LATCH: begin
               oBUSY   <= 1'b1;
               oBCD    <= bcd_r;
               oHEX0   <= segEncode(bcd_r[3:0], 1'b0);
               oHEX1   <= segEncode(bcd_r[7:4], tensBlank_s);
               oHEX2   <= segEncode(bcd_r[11:8], hundBlank_s);
               oDONE   <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               oBUSY   <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Randomised and directed checks of bcd_seg_display against a decimal-arithmetic
// reference model of the digits, blanking and segment patterns.
module tb_bcd_seg_display;

   logic        iCLK_50 = 1'b0;
   logic        iRST_N;
   logic [7:0]  iVALUE;
   logic [6:0]  oHEX0;
   logic [6:0]  oHEX1;
   logic [6:0]  oHEX2;
   logic [11:0] oBCD;
   logic        oBUSY;
   logic        oDONE;

   int checkCount = 0;
   int passCount  = 0;
   int shownValue = 0;

   logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #10 iCLK_50 = ~iCLK_50;

   bcd_seg_display #(.BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
      .iCLK_50(iCLK_50),
      .iRST_N (iRST_N),
      .iVALUE (iVALUE),
      .oHEX0  (oHEX0),
      .oHEX1  (oHEX1),
      .oHEX2  (oHEX2),
      .oBCD   (oBCD),
      .oBUSY  (oBUSY),
      .oDONE  (oDONE)
   );

   task automatic checkValue(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iCLK_50);
         #1;
      end
   endtask

   function automatic int modelSeg(input int digit, input bit blank);
      if (blank) return 32'h7F;
      return int'(segTable[digit]);
   endfunction

   task automatic checkDisplay(input int v);
      int h = v / 100;
      int t = (v / 10) % 10;
      int o = v % 10;
      checkValue("bcd",  oBCD,  (h << 8) | (t << 4) | o);
      checkValue("hex2", oHEX2, modelSeg(h, h == 0));
      checkValue("hex1", oHEX1, modelSeg(t, (h == 0) && (t == 0)));
      checkValue("hex0", oHEX0, modelSeg(o, 1'b0));
   endtask

   task automatic waitDone(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick(1);
         if (oDONE) got = 1'b1;
      end
      if (!got) checkValue("doneTimeout", 0, 1);
   endtask

   task automatic convert(input int v);
      bit got;
      iVALUE = v[7:0];
      waitDone(40, got);
      if (got) begin
         checkDisplay(v);
         tick(1);
         checkValue("donePulse", oDONE, 0);
      end
      shownValue = v;
   endtask

   task automatic expectQuiet(input int cycles, input int v);
      int doneSeen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick(1);
         if (oDONE) doneSeen++;
      end
      checkValue("noDone", doneSeen, 0);
      checkValue("idleBusy", oBUSY, 0);
      checkDisplay(v);
   endtask

   initial begin
      bit got;
      int v;
      int corner[$] = '{0, 9, 10, 99, 1, 250};

      // Reset state with a zero input.
      iRST_N = 1'b0;
      iVALUE = 8'd0;
      #25;
      checkDisplay(0);
      checkValue("rstBusy", oBUSY, 0);
      checkValue("rstDone", oDONE, 0);
      tick(2);
      iRST_N = 1'b1;
      expectQuiet(50, 0);

      // 255 with exact latency counted from edge 0.
      iVALUE = 8'd255;
      tick(2);
      checkValue("busyE1", oBUSY, 0);
      tick(1);
      checkValue("busyE2", oBUSY, 1);
      tick(8);
      checkValue("doneE10", oDONE, 0);
      checkValue("busyE10", oBUSY, 1);
      tick(1);
      checkValue("doneE11", oDONE, 1);
      checkValue("busyE11", oBUSY, 1);
      checkDisplay(255);
      tick(1);
      checkValue("doneE12", oDONE, 0);
      checkValue("busyE12", oBUSY, 0);
      shownValue = 255;

      convert(7);
      convert(100);

      // One-sample glitch is filtered out.
      iVALUE = 8'd5;
      tick(1);
      iVALUE = 8'd100;
      expectQuiet(30, 100);

      // Value changes mid-conversion: both results appear, busy gaps between.
      iVALUE = 8'd12;
      tick(6);
      iVALUE = 8'd34;
      waitDone(40, got);
      if (got) begin
         checkDisplay(12);
         tick(1);
         checkValue("busyGap", oBUSY, 0);
         checkValue("donePulse12", oDONE, 0);
      end
      waitDone(40, got);
      if (got) begin
         checkDisplay(34);
         tick(1);
      end
      shownValue = 34;

      // Reset during SHIFT discards the conversion.
      iVALUE = 8'd200;
      tick(6);
      iRST_N = 1'b0;
      #1;
      checkDisplay(0);
      checkValue("midRstBusy", oBUSY, 0);
      checkValue("midRstDone", oDONE, 0);
      tick(2);
      iRST_N = 1'b1;
      convert(200);

      foreach (corner[i]) convert(corner[i]);

      // Random values, some preceded by a single-sample glitch.
      for (int n = 0; n < 24; n++) begin
         v = int'($urandom_range(0, 255));
         if (v == shownValue) v = (v + 1) % 256;
         if ($urandom_range(0, 3) == 0) begin
            iVALUE = 8'($urandom_range(0, 255));
            tick(1);
         end
         convert(v);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/bcd_seg_display.md
# bcd_seg_display

Downstream display stage for the free-running 8-bit tick counter. Converts the counter value to three BCD digits with a sequential shift-add-3 (double-dabble) engine and drives three DE2 seven-segment displays (hundreds, tens, ones). The counter value is produced by logic clocked from a divided tick, so the input is treated as asynchronous. It is only converted after it has been stable for two consecutive samples and differs from the last converted value.

## Interface
- BLANK_LEADING, 1: 1 = blank leading zero digits (ones digit never blanked); 0 = always show all three digits.
- SEG_ACTIVE_LOW, 1: 1 = segment on is driven 0 (DE2 HEX); 0 = segment on is driven 1.
- iCLK_50  in  1  50 MHz system clock; the only clock; all state changes on its rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iVALUE  in  8  binary value to display, asynchronous to iCLK_50.
- oHEX0  out  7  ones digit segments, bit order {g,f,e,d,c,b,a}, bit0 = a.
- oHEX1  out  7  tens digit segments.
- oHEX2  out  7  hundreds digit segments.
- oBCD  out  12  registered BCD result {hundreds, tens, ones}.
- oBUSY  out  1  high while a conversion is in progress (SHIFT or LATCH state).
- oDONE  out  1  one-cycle pulse when oHEX*/oBCD update.

## Operation
- Input capture: s1 <= iVALUE; s2 <= s1, every cycle, in all states.
- Registers: state {IDLE, SHIFT, LATCH}; shift register sh[7:0]; accumulator bcd[11:0]; 3-bit shift count; last[7:0] (last converted value).
- IDLE: if s1 == s2 and s2 != last, then load sh <= s2, bcd <= 0, last <= s2, count <= 0, and go to SHIFT. Otherwise hold.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5 (combinational on current bcd), then shift {bcd, sh} left by one. Increment count. After the 8th shift (count == 7), go to LATCH.
- LATCH: oBCD <= bcd; oHEX0/1/2 <= encoded digits; oDONE <= 1; go to IDLE.
- Changes to iVALUE during SHIFT/LATCH are not aborted. They are picked up by the IDLE compare afterwards, because last holds the old value.
- Segment codes (active-low, SEG_ACTIVE_LOW = 1): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F. When SEG_ACTIVE_LOW = 0, all codes are bitwise inverted (blank = 0x00).
- Blanking (BLANK_LEADING = 1):
  - Hundreds is blank when it is 0.
  - Tens is blank when hundreds and tens are both 0.
  - Ones is never blanked.
  - Interior zeros are never blanked (100 shows "1 0 0").
- Width rule: maximum input 255 gives maximum BCD 0x255. The hundreds nibble never exceeds 2, so codes for 10–15 are unreachable; they map to blank.

## Timing
- Reset values (asynchronous, immediate on iRST_N low):
  - state = IDLE; s1 = s2 = last = 0; bcd = 0; sh = 0; count = 0.
  - oBCD = 0x000; oBUSY = 0; oDONE = 0.
  - oHEX0 = "0" (0x40); oHEX1 = oHEX2 = blank (0x7F) when BLANK_LEADING = 1, else 0x40.
- Release of reset with iVALUE = 0 triggers no conversion (last = 0).
- Latency, with edge 0 defined as the first edge sampling a new stable value into s1:
  - s2 matches at edge 1.
  - Load/enter SHIFT at edge 2.
  - Shifts occur at edges 3–10.
  - LATCH is entered after edge 10.
  - Outputs update and oDONE is high after edge 11, for exactly one cycle.
- oBUSY is high after edges 2 through 11 inclusive and low after edge 12.
- Glitch filter: a value present for only one sample (s1 != s2 at the IDLE check) is never converted.
- Back-to-back: a new value that stabilises during a conversion starts its conversion at the first IDLE cycle (edge 12 at earliest).
- Reset asserted mid-SHIFT: conversion is discarded and all outputs take reset values. After release, the current iVALUE is converted if it is non-zero.

## Test plan
- Reset with iVALUE = 0 -> oHEX2 = 0x7F, oHEX1 = 0x7F, oHEX0 = 0x40, oBUSY = 0, and no oDONE pulse for 50 cycles.
- iVALUE = 255 -> exactly 11 edges after capture: oBCD = 0x255, oHEX2 = 0x24, oHEX1 = 0x12, oHEX0 = 0x12, single-cycle oDONE.
- iVALUE = 7, then 100 -> first result oHEX2 = oHEX1 = 0x7F, oHEX0 = 0x78; second result oHEX2 = 0x79, oHEX1 = 0x40, oHEX0 = 0x40.
- iVALUE 0 -> 5 for one cycle -> back to 0 -> no conversion, no oDONE, outputs unchanged.
- iVALUE 12, changed to 34 at the 4th SHIFT cycle -> oBCD = 0x012 with oDONE, then a second oDONE with oBCD = 0x034. oBUSY drops for at least one cycle between the two conversions.
- iVALUE 200, iRST_N pulsed low during SHIFT -> outputs return to reset values immediately. After release, oBCD = 0x200 and oHEX2 = 0x24, oHEX1 = oHEX0 = 0x40.
